// File: rtl/axi_wr_router.sv
// axi_wr_router: forwards the granted AW request and steers W beats and B responses in accepted-burst order
module axi_wr_router #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_wgrnt,
    input  logic                m1_wgrnt,
    input  logic [ADDR_W-1:0]   m0_AWADDR,
    input  logic [7:0]          m0_AWLEN,
    input  logic                m0_AWVALID,
    output logic                m0_AWREADY,
    input  logic [ADDR_W-1:0]   m1_AWADDR,
    input  logic [7:0]          m1_AWLEN,
    input  logic                m1_AWVALID,
    output logic                m1_AWREADY,
    input  logic [DATA_W-1:0]   m0_WDATA,
    input  logic [DATA_W/8-1:0] m0_WSTRB,
    input  logic                m0_WLAST,
    input  logic                m0_WVALID,
    output logic                m0_WREADY,
    input  logic [DATA_W-1:0]   m1_WDATA,
    input  logic [DATA_W/8-1:0] m1_WSTRB,
    input  logic                m1_WLAST,
    input  logic                m1_WVALID,
    output logic                m1_WREADY,
    output logic [1:0]          m0_BRESP,
    output logic                m0_BVALID,
    input  logic                m0_BREADY,
    output logic [1:0]          m1_BRESP,
    output logic                m1_BVALID,
    input  logic                m1_BREADY,
    output logic [ADDR_W-1:0]   s_AWADDR,
    output logic [7:0]          s_AWLEN,
    output logic                s_AWVALID,
    input  logic                s_AWREADY,
    output logic [DATA_W-1:0]   s_WDATA,
    output logic [DATA_W/8-1:0] s_WSTRB,
    output logic                s_WLAST,
    output logic                s_WVALID,
    input  logic                s_WREADY,
    input  logic [1:0]          s_BRESP,
    input  logic                s_BVALID,
    output logic                s_BREADY
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [MAX_OUTSTANDING-1:0] wq, bq;
    logic [PW-1:0] w_rd, w_wr, b_rd, b_wr;
    logic [CW-1:0] w_n, b_n, cnt;
    logic sel, aw_ok, aw_hs, w_ne, b_ne, h, b, w_last_hs, b_hs;

    // AW forwarding from the grant, W/B steering from the heads of the order FIFOs
    always_comb begin
        sel        = m1_wgrnt;
        aw_ok      = (m0_wgrnt ^ m1_wgrnt) && (cnt < CW'(MAX_OUTSTANDING));
        s_AWADDR   = sel ? m1_AWADDR : m0_AWADDR;
        s_AWLEN    = sel ? m1_AWLEN : m0_AWLEN;
        s_AWVALID  = aw_ok && (sel ? m1_AWVALID : m0_AWVALID);
        m0_AWREADY = aw_ok && !sel && s_AWREADY;
        m1_AWREADY = aw_ok && sel && s_AWREADY;
        aw_hs      = s_AWVALID && s_AWREADY;
        w_ne       = w_n != '0;
        h          = wq[w_rd];
        s_WDATA    = h ? m1_WDATA : m0_WDATA;
        s_WSTRB    = h ? m1_WSTRB : m0_WSTRB;
        s_WLAST    = h ? m1_WLAST : m0_WLAST;
        s_WVALID   = w_ne && (h ? m1_WVALID : m0_WVALID);
        m0_WREADY  = w_ne && !h && s_WREADY;
        m1_WREADY  = w_ne && h && s_WREADY;
        w_last_hs  = s_WVALID && s_WREADY && s_WLAST;
        b_ne       = b_n != '0;
        b          = bq[b_rd];
        m0_BVALID  = b_ne && !b && s_BVALID;
        m1_BVALID  = b_ne && b && s_BVALID;
        m0_BRESP   = (b_ne && !b) ? s_BRESP : 2'b00;
        m1_BRESP   = (b_ne && b) ? s_BRESP : 2'b00;
        s_BREADY   = b_ne && (b ? m1_BREADY : m0_BREADY);
        b_hs       = s_BVALID && s_BREADY;
    end

    // order FIFOs and outstanding counter; a WLAST moves the burst's master from W order to B order
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wq   <= '0;
            bq   <= '0;
            w_rd <= '0;
            w_wr <= '0;
            b_rd <= '0;
            b_wr <= '0;
            w_n  <= '0;
            b_n  <= '0;
            cnt  <= '0;
        end else begin
            if (aw_hs) begin
                wq[w_wr] <= sel;
                w_wr     <= w_wr + 1'b1;
            end
            if (w_last_hs) begin
                bq[b_wr] <= h;
                b_wr     <= b_wr + 1'b1;
                w_rd     <= w_rd + 1'b1;
            end
            if (b_hs) b_rd <= b_rd + 1'b1;
            w_n <= w_n + CW'(aw_hs) - CW'(w_last_hs);
            b_n <= b_n + CW'(w_last_hs) - CW'(b_hs);
            cnt <= cnt + CW'(aw_hs) - CW'(b_hs);
        end
    end

    a_w_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
        !(aw_hs && !w_last_hs && w_n == CW'(MAX_OUTSTANDING)));
    a_b_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_last_hs && !b_hs && b_n == CW'(MAX_OUTSTANDING)));
endmodule
